// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle for sync_fifo_fwft: write side, read side, occupancy and status flags.
// The FIFO connects through the slave modport and the producer/consumer through the master modport.
interface sync_fifo_fwft_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: a (DEPTH-1)-word ring plus a registered head word.
// Defining SYNC_FIFO_FWFT_ERR_FLAGS_EN compiles the sticky overflow/underflow flags.
module sync_fifo_fwft #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    sync_fifo_fwft_if.slave  f
);
    localparam int                  DEPTH    = 2**ADDR_WIDTH;
    localparam int                  CW       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH-1];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  push, pop, arr_empty, load;

    // Ring index runs 0..DEPTH-2; the MSB toggles on each wrap to tell full from empty.
    function automatic logic [ADDR_WIDTH:0] ptr_inc(input logic [ADDR_WIDTH:0] p);
        if (p[ADDR_WIDTH-1:0] == LAST_IDX) begin
            return {~p[ADDR_WIDTH], {ADDR_WIDTH{1'b0}}};
        end
        return {p[ADDR_WIDTH], p[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1)};
    endfunction

    assign f.in_ready     = (count_q != DEPTH_C);
    assign push           = f.in_valid && f.in_ready;
    assign pop            = out_valid_q && f.out_ready;
    assign arr_empty      = (wr_ptr_q == rd_ptr_q);
    assign load           = (!out_valid_q || pop) && !arr_empty;

    assign f.out_valid    = out_valid_q;
    assign f.out_data     = out_data_q;
    assign f.count        = count_q;
    assign f.almost_full  = (int'(count_q) >= AFULL_THRESH);
    assign f.almost_empty = (int'(count_q) <= AEMPTY_THRESH);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (clr_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (load) begin
                rd_ptr_d    = ptr_inc(rd_ptr_q);
                out_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array carries no reset; only pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= f.in_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (f.in_valid && !f.in_ready) overflow_d = 1'b1;
            if (f.out_ready && !out_valid_q) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign f.overflow  = overflow_q;
    assign f.underflow = underflow_q;
`else
    assign f.overflow  = 1'b0;
    assign f.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: vector table, directed corner sequences and random traffic
// compared against a queue-based model of the FIFO.
module tb_sync_fifo_fwft;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    sync_fifo_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sync_fifo_fwft #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .f(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: every held word in arrival order, plus whether the head is visible.
    logic [DW-1:0] mq[$];
    bit mvis = 1'b0;
    bit movf = 1'b0;
    bit mudf = 1'b0;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          c;
        logic          eov;
        logic [DW-1:0] eod;
        logic [AW:0]   ecnt;
        logic          eir;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("count", 32'(bus.count), 32'(sz));
        chk("in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(mvis));
        if (mvis) chk("out_data", 32'(bus.out_data), 32'(mq[0]));
        chk("almost_full", 32'(bus.almost_full), 32'(sz >= AFT));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AET));
`ifdef SYNC_FIFO_FWFT_ERR_FLAGS_EN
        chk("overflow", 32'(bus.overflow), 32'(movf));
        chk("underflow", 32'(bus.underflow), 32'(mudf));
`else
        chk("overflow", 32'(bus.overflow), 32'(0));
        chk("underflow", 32'(bus.underflow), 32'(0));
`endif
    endtask

    // One clock: predict from current inputs, take the edge, then compare.
    task automatic cycle();
        int sz;
        bit pu, po, nv, iv, ordy, c;
        logic [DW-1:0] din;
        sz   = mq.size();
        iv   = bus.in_valid;
        ordy = bus.out_ready;
        c    = clr;
        din  = bus.in_data;
        pu   = iv && (sz < DEPTH);
        po   = mvis && ordy;
        nv   = (mvis && !po) || ((sz - int'(mvis)) > 0);
        @(posedge clk);
        #1;
        if (c) begin
            mq.delete();
            mvis = 1'b0;
            movf = 1'b0;
            mudf = 1'b0;
        end else begin
            if (iv && sz >= DEPTH) movf = 1'b1;
            if (ordy && !mvis) mudf = 1'b1;
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(din);
            mvis = nv;
        end
        check_model();
    endtask

    task automatic async_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clr           = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("rst_count", 32'(bus.count), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_almost_empty", 32'(bus.almost_empty), 32'(1));
        chk("rst_almost_full", 32'(bus.almost_full), 32'(0));
        chk("rst_overflow", 32'(bus.overflow), 32'(0));
        chk("rst_underflow", 32'(bus.underflow), 32'(0));
        #2 rst = 1'b0;
        mq.delete();
        mvis = 1'b0;
        movf = 1'b0;
        mudf = 1'b0;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    initial begin
        int nexp;
        int gaps;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        async_reset();

        // Empty-side behaviour: bubble, single-word push/pop, drain, flush.
        tv[0] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b1};
        tv[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 5'd1, 1'b1};
        tv[2] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0001, 5'd1, 1'b1};
        tv[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 5'd1, 1'b1};
        tv[4] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0002, 5'd2, 1'b1};
        tv[5] = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0003, 5'd2, 1'b1};
        tv[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004, 5'd1, 1'b1};
        tv[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0004, 5'd0, 1'b1};
        tv[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0004, 5'd0, 1'b1};
        tv[9] = '{1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, 16'h0004, 5'd0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].iv, tv[i].d, tv[i].ordy);
            clr = tv[i].c;
            cycle();
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tv[i].eov));
            chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(tv[i].eod));
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tv[i].ecnt));
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].eir));
        end
        clr = 1'b0;

        // Fill to capacity, overflow attempt, pop at full, ordered drain.
        async_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            cycle();
        end
        chk("full_count", 32'(bus.count), 32'(16));
        chk("full_in_ready", 32'(bus.in_ready), 32'(0));
        chk("full_almost_full", 32'(bus.almost_full), 32'(1));
        drive(1'b1, 16'hDEAD, 1'b0);
        cycle();
        chk("ovf_count", 32'(bus.count), 32'(16));
`ifdef SYNC_FIFO_FWFT_ERR_FLAGS_EN
        chk("overflow_set", 32'(bus.overflow), 32'(1));
`endif
        drive(1'b1, 16'hBEEF, 1'b1);
        chk("pop_at_full_word", 32'(bus.out_data), 32'(0));
        cycle();
        chk("pop_at_full_count", 32'(bus.count), 32'(15));
        chk("pop_at_full_in_ready", 32'(bus.in_ready), 32'(1));
        drive(1'b0, '0, 1'b1);
        nexp = 1;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid) begin
                chk("drain_order", 32'(bus.out_data), 32'(nexp));
                nexp++;
            end
            if (bus.count == 5'd2) chk("aempty_at2", 32'(bus.almost_empty), 32'(1));
            if (bus.count == 5'd3) chk("aempty_at3", 32'(bus.almost_empty), 32'(0));
            cycle();
        end
        chk("drain_total", 32'(nexp), 32'(16));

        // Continuous streaming across several pointer wraps.
        async_reset();
        nexp = 0;
        gaps = 0;
        for (int i = 0; i < 70; i++) begin
            drive(i < 64, 16'(i), 1'b1);
            if (bus.out_valid) begin
                chk("stream_order", 32'(bus.out_data), 32'(nexp));
                nexp++;
            end else if (nexp > 0 && nexp < 64) begin
                gaps++;
            end
            cycle();
        end
        chk("stream_gaps", 32'(gaps), 32'(0));
        chk("stream_total", 32'(nexp), 32'(64));

        // Stalled head stays stable, then flush.
        async_reset();
        drive(1'b1, 16'hA5A5, 1'b0); cycle();
        drive(1'b1, 16'h0001, 1'b0); cycle();
        drive(1'b1, 16'h0002, 1'b0); cycle();
        drive(1'b0, '0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("hold_data", 32'(bus.out_data), 32'(16'hA5A5));
            chk("hold_valid", 32'(bus.out_valid), 32'(1));
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr_count", 32'(bus.count), 32'(0));
        chk("clr_out_valid", 32'(bus.out_valid), 32'(0));
        chk("clr_in_ready", 32'(bus.in_ready), 32'(1));

        // Asynchronous reset mid-stream, then pop on empty.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), i[0]);
            cycle();
        end
        async_reset();
        drive(1'b0, '0, 1'b1);
        cycle();
`ifdef SYNC_FIFO_FWFT_ERR_FLAGS_EN
        chk("underflow_set", 32'(bus.underflow), 32'(1));
`endif

        // Random traffic with varying consumer pressure and occasional flush.
        async_reset();
        for (int n = 0; n < 1500; n++) begin
            int phase;
            logic ordy;
            phase = (n / 200) % 3;
            case (phase)
                0:       ordy = ($urandom_range(0, 3) == 0);
                1:       ordy = ($urandom_range(0, 1) == 0);
                default: ordy = ($urandom_range(0, 7) != 0);
            endcase
            drive($urandom_range(0, 3) != 0, 16'($urandom), ordy);
            clr = ($urandom_range(0, 99) == 0);
            cycle();
        end
        clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Parametrised successor to the team's basic synchronous FIFO.
- First-word-fall-through (FWFT) buffer with valid/ready handshakes on both sides, a registered output stage, an occupancy count, almost-full/almost-empty thresholds and a synchronous flush.
- Sits between the syndrome/error-locator stages and the Forney evaluator in the RS(544,514) decoder. It absorbs per-codeword burst mismatch without downstream stall logic.

Parameters:
ADDR_WIDTH, 4, log2 of total capacity; DEPTH = 2**ADDR_WIDTH words (array + output register combined)
DATA_WIDTH, 16, word width in bits
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
clr_i  in  1  synchronous flush, active-high
in_valid  in  1  write request
in_data  in  DATA_WIDTH  write data
in_ready  out  1  space available (count < DEPTH)
out_valid  out  1  out_data holds the oldest word
out_data  out  DATA_WIDTH  head word, registered
out_ready  in  1  consumer accepts the head word
count  out  ADDR_WIDTH+1  words held, 0..DEPTH
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
overflow  out  1  sticky error flag (see Optional Feature)
underflow  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (rst_i high, async):
  - pointers = 0, count = 0, out_valid = 0, out_data = 0, overflow = underflow = 0.
  - in_ready = 1, almost_empty = 1, almost_full = 0.
- Definitions:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Only these events change state; in_valid while !in_ready and out_ready while !out_valid are ignored.
- Storage:
  - Array of DEPTH-1 words plus one output register.
  - wr_ptr/rd_ptr are ADDR_WIDTH+1 bits with a wrap bit.
  - The array is full when the MSBs differ and the low bits are equal; it is empty when the pointers are equal.
  - Pointers wrap modulo 2*(DEPTH-1) ring positions. Implementer's choice: ADDR_WIDTH-bit index with an explicit wrap toggle at DEPTH-2.
- Prefetch:
  - Whenever the output register is empty, or is being popped this cycle, and the array is non-empty, the array head loads into out_data at the next edge.
  - out_valid is set at that edge.
- Latency:
  - A word pushed into an empty FIFO at edge N appears with out_valid = 1 after edge N+1 (one-cycle bubble).
  - Back-to-back streaming sustains 1 word/cycle in steady state.
- Ordering: strict FIFO; out_data is stable while out_valid && !out_ready.
- count:
  - Increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - count includes the output register.
  - in_ready = (count != DEPTH), combinational from registered count.
- Full boundary: at count = DEPTH, in_ready = 0 even if pop occurs in the same cycle (no full pass-through). in_ready rises the cycle after the pop.
- Empty boundary: at count = 1 with simultaneous push and pop, count stays 1 and the new word reaches out_data one edge later. out_valid drops for one cycle only if the new word is still in the array.
- Flags: almost_full and almost_empty are combinational from count, with no extra latency.
- clr_i:
  - At the next edge, same effect as reset on pointers, count, out_valid and flags; out_data is not cleared.
  - Push and pop in the same cycle are discarded.
  - clr_i has priority over all other events.
- Reset mid-stream: all contents are lost; out_valid drops immediately (async).

Optional Feature:
- Macro: SYNC_FIFO_FWFT_ERR_FLAGS_EN.
- Defined:
  - overflow is set at the edge where in_valid && !in_ready.
  - underflow is set at the edge where out_ready && !out_valid.
  - Both flags are sticky until rst_i or clr_i.
- Undefined: overflow and underflow are tied to 0 and their logic is not compiled.

Test Plan:
1. Reset, then push 0x0001 into the empty FIFO at edge 1 -> out_valid = 1 and out_data = 0x0001 after edge 2; count = 1 after edge 1.
2. ADDR_WIDTH = 4: push 16 words (0x0000..0x000F) with out_ready = 0 -> in_ready = 0 and count = 16. A further in_valid is ignored (overflow = 1 with the macro defined). Then drain -> words are 0x0000..0x000F in order, and almost_empty asserts at count = 2.
3. At count = 16, assert in_valid and out_ready together -> pop only; count = 15 and in_ready = 1 next cycle.
4. Continuous push and pop of 64 incrementing words with wrap-around -> after the first word, out_valid stays high and the output sequence is unbroken with no loss or duplication.
5. Hold out_ready = 0 with 3 words queued -> out_data stays 0xA5A5 (the head) for 10 cycles. Pulse clr_i -> count = 0, out_valid = 0 and in_ready = 1 next edge.
6. Assert rst_i asynchronously mid-stream -> count = 0 and out_valid = 0 without waiting for a clock edge. Pop on empty with the macro defined -> underflow = 1.
